// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bundle: decode-side inputs, forwarding sources and ALU-facing outputs.
// The slave modport belongs to id_ex_stage and the master modport to whatever drives decode.
interface id_ex_stage_if;
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic [31:0] i_imm;
  logic [4:0]  i_shamt;
  logic [4:0]  i_rs;
  logic [4:0]  i_rt;
  logic [4:0]  i_rd;
  logic [3:0]  i_alu_op;
  logic        i_alu_src;
  logic        i_shift_src;
  logic        i_reg_dst;
  logic        i_reg_write;
  logic        i_exmem_reg_write;
  logic [4:0]  i_exmem_rd;
  logic [31:0] i_exmem_res;
  logic        i_memwb_reg_write;
  logic [4:0]  i_memwb_rd;
  logic [31:0] i_memwb_data;
  logic [31:0] o_A;
  logic [31:0] o_B;
  logic [3:0]  o_operation;
  logic [31:0] o_store_data;
  logic [4:0]  o_dest;
  logic        o_reg_write;
  logic        o_valid;

  modport slave (
    input  i_stall, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_shamt,
           i_rs, i_rt, i_rd, i_alu_op, i_alu_src, i_shift_src, i_reg_dst, i_reg_write,
           i_exmem_reg_write, i_exmem_rd, i_exmem_res,
           i_memwb_reg_write, i_memwb_rd, i_memwb_data,
    output o_A, o_B, o_operation, o_store_data, o_dest, o_reg_write, o_valid
  );

  modport master (
    output i_stall, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_shamt,
           i_rs, i_rt, i_rd, i_alu_op, i_alu_src, i_shift_src, i_reg_dst, i_reg_write,
           i_exmem_reg_write, i_exmem_rd, i_exmem_res,
           i_memwb_reg_write, i_memwb_rd, i_memwb_data,
    input  o_A, o_B, o_operation, o_store_data, o_dest, o_reg_write, o_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection and optional EX/MEM, MEM/WB forwarding.
// Build macro FORWARDING_EN enables forwarding; without it the forwarding inputs are ignored.
module id_ex_stage (
  input logic         i_clk,
  input logic         i_reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        shift_src;
    logic        reg_dst;
    logic        reg_write;
  } id_ex_t;

  id_ex_t stage_q;
  id_ex_t stage_d;
  id_ex_t capture;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  always_comb begin
    capture           = '0;
    capture.valid     = 1'b1;
    capture.rs_data   = bus.i_rs_data;
    capture.rt_data   = bus.i_rt_data;
    capture.imm       = bus.i_imm;
    capture.shamt     = bus.i_shamt;
    capture.rs        = bus.i_rs;
    capture.rt        = bus.i_rt;
    capture.rd        = bus.i_rd;
    capture.alu_op    = bus.i_alu_op;
    capture.alu_src   = bus.i_alu_src;
    capture.shift_src = bus.i_shift_src;
    capture.reg_dst   = bus.i_reg_dst;
    capture.reg_write = bus.i_reg_write;
  end

  // An invalid decode slot is stored as the same all-zero bubble a flush produces.
  always_comb begin
    stage_d = '0;
    if (bus.i_flush) begin
      stage_d = '0;
    end else if (bus.i_stall) begin
      stage_d = stage_q;
    end else if (bus.i_valid) begin
      stage_d = capture;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef FORWARDING_EN
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] reg_val,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_val,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_val
  );
    if (idx != 5'd0 && ex_we && ex_rd == idx) begin
      return ex_val;
    end else if (idx != 5'd0 && wb_we && wb_rd == idx) begin
      return wb_val;
    end
    return reg_val;
  endfunction

  assign fwd_rs = fwd_sel(stage_q.rs, stage_q.rs_data,
                          bus.i_exmem_reg_write, bus.i_exmem_rd, bus.i_exmem_res,
                          bus.i_memwb_reg_write, bus.i_memwb_rd, bus.i_memwb_data);
  assign fwd_rt = fwd_sel(stage_q.rt, stage_q.rt_data,
                          bus.i_exmem_reg_write, bus.i_exmem_rd, bus.i_exmem_res,
                          bus.i_memwb_reg_write, bus.i_memwb_rd, bus.i_memwb_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{stage_q.rs, stage_q.rt,
                        bus.i_exmem_reg_write, bus.i_exmem_rd, bus.i_exmem_res,
                        bus.i_memwb_reg_write, bus.i_memwb_rd, bus.i_memwb_data};
  assign fwd_rs = stage_q.rs_data;
  assign fwd_rt = stage_q.rt_data;
`endif

  assign bus.o_A          = stage_q.shift_src ? {27'b0, stage_q.shamt} : fwd_rs;
  assign bus.o_B          = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign bus.o_store_data = fwd_rt;
  assign bus.o_operation  = stage_q.alu_op;
  assign bus.o_dest       = stage_q.reg_dst ? stage_q.rd : stage_q.rt;
  assign bus.o_reg_write  = stage_q.reg_write & stage_q.valid;
  assign bus.o_valid      = stage_q.valid;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named i_clk and i_reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  rising-edge clock
- i_reset  in  1  synchronous active-high reset
- i_stall  in  1  hold stage contents
- i_flush  in  1  replace contents with bubble
- i_valid  in  1  decode-stage instruction valid
- i_rs_data / i_rt_data  in  32  register-file read values
- i_imm  in  32  immediate, already extended by decode
- i_shamt  in  5  shift amount field
- i_rs / i_rt / i_rd  in  5  register indices
- i_alu_op  in  4  ALU operation code (0000 ADD .. 1101 LUI)
- i_alu_src  in  1  1: B operand = immediate
- i_shift_src  in  1  1: A operand = zero-extended shamt
- i_reg_dst  in  1  1: destination = rd, 0: rt
- i_reg_write  in  1  instruction writes register file
- i_exmem_reg_write  in  1;  i_exmem_rd  in  5;  i_exmem_res  in  32  EX/MEM forwarding source
- i_memwb_reg_write  in  1;  i_memwb_rd  in  5;  i_memwb_data  in  32  MEM/WB forwarding source
- o_A / o_B  out  32  ALU operands
- o_operation  out  4  ALU operation
- o_store_data  out  32  forwarded rt value for stores
- o_dest  out  5  selected destination register
- o_reg_write  out  1  write enable, gated by valid
- o_valid  out  1  stage holds a valid instruction

Function
REQ-003 SHALL register all decode inputs on the rising edge of i_clk; latency decode->outputs = 1 cycle.
REQ-004 SHALL apply edge priority: i_reset > i_flush > i_stall > capture.
REQ-005 Flush SHALL load a bubble: all stored fields 0, so o_valid=0, o_reg_write=0, o_operation=0000, o_dest=0.
REQ-006 Stall SHALL hold every stored field unchanged; outputs may still change via forwarding inputs.
REQ-007 Capture with i_valid=0 SHALL store a bubble identical to REQ-005.
REQ-008 o_reg_write SHALL equal stored reg_write AND stored valid.
REQ-009 o_dest SHALL be stored rd when stored reg_dst=1, else stored rt.
REQ-010 Forwarded rs/rt (fwd_rs, fwd_rt) SHALL be combinational from registered indices: EX/MEM match first, then MEM/WB match, else registered data.
REQ-011 A forwarding match SHALL require source reg_write=1, source rd equal to index, and index != 0; index 0 never forwards.
REQ-012 o_A SHALL be {27'b0, stored shamt} when shift_src=1, else fwd_rs.
REQ-013 o_B SHALL be stored imm when alu_src=1, else fwd_rt; o_store_data SHALL always be fwd_rt.
REQ-014 o_operation SHALL be stored alu_op unmodified.

Reset
REQ-015 On i_reset=1 at a clock edge, all stored fields SHALL clear to 0; outputs then: o_A=0, o_B=0, o_operation=0000, o_store_data=0, o_dest=0, o_reg_write=0, o_valid=0.
REQ-016 Reset asserted during stall or flush SHALL clear identically; first capture occurs on the first edge with i_reset=0.

Configuration
REQ-017 Macro FORWARDING_EN: defined -> REQ-010/011 forwarding active; undefined -> fwd_rs/fwd_rt SHALL equal registered rs/rt data, and the EX/MEM and MEM/WB inputs SHALL be ignored (ports retained).

Verification
REQ-018 Reset: hold i_reset 2 cycles with nonzero inputs -> all outputs 0 per REQ-015.
REQ-019 ADD capture: rs_data=1, rt_data=5, alu_op=0000, alu_src=0, valid=1 -> next cycle o_A=1, o_B=5, o_operation=0000, o_valid=1.
REQ-020 SLL shamt: shift_src=1, shamt=4, rt_data=0x1F, alu_op=0111 -> o_A=0x00000004, o_B=0x0000001F.
REQ-021 Forward priority (FORWARDING_EN): rs=3, exmem rd=3 res=0xAAAA, memwb rd=3 data=0xBBBB, both write=1 -> o_A=0xAAAA; exmem write=0 -> o_A=0xBBBB; rs=0 -> o_A=rs_data.
REQ-022 Stall/flush: capture LUI (alu_op=1101, alu_src=1, imm=0x1001), assert stall 3 cycles with changing inputs -> outputs hold; assert flush and stall together -> next cycle o_valid=0, o_reg_write=0, o_operation=0000.
REQ-023 Without FORWARDING_EN: repeat REQ-021 -> o_A equals registered rs_data in all cases.
